processa_tiro: RTL and testbench

Shot-resolution engine for the Battleship board map memory. It accepts one shot (row, column) at a time over a valid/ready handshake and reads the addressed 36-bit row from the map memory. It classifies the target cell, writes the row back with the cell marked as shot, and returns a result code. It also keeps the running hit count and raises a sticky game-over flag once every ship cell has been hit. It sits between the game controller (player input side) and the board map memory, driving that memory's clock-shared write-enable/address/data port.

---
 rtl/processa_tiro_if.sv | 26 ++
 rtl/processa_tiro.sv | 139 +++++++++++++
 tb/tb_processa_tiro.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/processa_tiro_if.sv
`default_nettype none
// ============================================================================
// Module   : processa_tiro_if
// Brief    : Shot request / result handshake bundle for the shot engine.
// Revision : 1.0
// ============================================================================
interface processa_tiro_if;
    logic       shot_valid;
    logic       shot_ready;
    logic [3:0] shot_row;
    logic [3:0] shot_col;
    logic       result_valid;
    logic       result_ready;
    logic [1:0] result;

    modport master (
        output shot_valid, shot_row, shot_col, result_ready,
        input  shot_ready, result_valid, result
    );

    modport slave (
        input  shot_valid, shot_row, shot_col, result_ready,
        output shot_ready, result_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/processa_tiro.sv
`default_nettype none
// ============================================================================
// Module   : processa_tiro
// Brief    : Battleship shot engine: read-modify-write of a board row, result
//            code, hit counter and sticky game-over flag.
// Revision : 1.0
// ============================================================================
module processa_tiro #(
    parameter int ROWS             = 11,
    parameter int COLS             = 12,
    parameter int TOTAL_SHIP_CELLS = 17
) (
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 new_game,
    processa_tiro_if.slave      shot_if,
    output logic [5:0]          hit_count,
    output logic                game_over,
    output logic                mem_we,
    output logic [3:0]          mem_addr,
    output logic [COLS*3-1:0]   mem_wdata,
    input  wire  [COLS*3-1:0]   mem_rdata
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_EVAL = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    localparam logic [1:0] c_MISS    = 2'b00;
    localparam logic [1:0] c_HIT     = 2'b01;
    localparam logic [1:0] c_REPEAT  = 2'b10;
    localparam logic [1:0] c_INVALID = 2'b11;

    localparam logic [3:0] c_ROWS  = 4'(ROWS);
    localparam logic [3:0] c_COLS  = 4'(COLS);
    localparam logic [5:0] c_TOTAL = 6'(TOTAL_SHIP_CELLS);

    logic [1:0]        r_state, w_next;
    logic [3:0]        r_col;
    logic [3:0]        r_addr;
    logic [1:0]        r_result;
    logic [5:0]        r_hit_count;
    logic              r_game_over;
    logic              w_ready, w_rvalid, w_we;
    logic              w_accept, w_in_range;
    logic [5:0]        w_base;
    logic              w_ship, w_shot;
    logic [COLS*3-1:0] w_mask;

    assign w_accept   = shot_if.shot_valid && w_ready;
    assign w_in_range = (shot_if.shot_row < c_ROWS) && (shot_if.shot_col < c_COLS);
    assign w_base     = {2'b00, r_col} * 6'd3;
    assign w_ship     = mem_rdata[w_base];
    assign w_shot     = mem_rdata[w_base + 6'd1];
    assign w_mask     = {{(COLS*3-1){1'b0}}, 1'b1} << (w_base + 6'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (new_game) begin
            w_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_accept) w_next = w_in_range ? c_ADDR : c_RESP;
                c_ADDR:  w_next = c_EVAL;
                c_EVAL:  w_next = c_RESP;
                c_RESP:  if (shot_if.result_ready) w_next = c_IDLE;
                default: w_next = c_IDLE;
            endcase
        end
    end

    // mem_we is decoded from state so an asynchronous reset drops it at once
    always_comb begin
        w_ready  = 1'b0;
        w_rvalid = 1'b0;
        w_we     = 1'b0;
        case (r_state)
            c_IDLE:  w_ready  = !r_game_over;
            c_EVAL:  w_we     = !w_shot && !new_game;
            c_RESP:  w_rvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_addr      <= '0;
            r_result    <= c_MISS;
            r_hit_count <= '0;
            r_game_over <= 1'b0;
        end else if (new_game) begin
            r_hit_count <= '0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            r_col  <= shot_if.shot_col;
                            r_addr <= shot_if.shot_row;
                        end else begin
                            r_result <= c_INVALID;
                        end
                    end
                end
                c_EVAL: begin
                    if (w_shot) begin
                        r_result <= c_REPEAT;
                    end else if (w_ship) begin
                        r_result <= c_HIT;
                        if (!r_game_over && r_hit_count != c_TOTAL) begin
                            r_hit_count <= r_hit_count + 6'd1;
                            if ((r_hit_count + 6'd1) == c_TOTAL) r_game_over <= 1'b1;
                        end
                    end else begin
                        r_result <= c_MISS;
                    end
                end
                default: ;
            endcase
        end
    end

    assign shot_if.shot_ready   = w_ready;
    assign shot_if.result_valid = w_rvalid;
    assign shot_if.result       = r_result;
    assign hit_count            = r_hit_count;
    assign game_over            = r_game_over;
    assign mem_we               = w_we;
    assign mem_addr             = r_addr;
    assign mem_wdata            = w_we ? (mem_rdata | w_mask) : '0;
endmodule
`default_nettype wire

// File: tb/tb_processa_tiro.sv
`default_nettype none
// ============================================================================
// Module   : tb_processa_tiro
// Brief    : Self-checking bench for processa_tiro with a board memory model.
// Revision : 1.0
// ============================================================================
module tb_processa_tiro;
    localparam logic [1:0] MISS = 2'b00, HIT = 2'b01, REPEAT = 2'b10, INVALID = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_game = 1'b0;
    logic [5:0]  hit_count;
    logic        game_over;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [35:0] mem_wdata;
    logic [35:0] mem_rdata;

    processa_tiro_if sif();

    processa_tiro #(.ROWS(11), .COLS(12), .TOTAL_SHIP_CELLS(17)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .new_game  (new_game),
        .shot_if   (sif.slave),
        .hit_count (hit_count),
        .game_over (game_over),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Board memory: registered read address, write on the rising edge
    logic [35:0] mem [0:15];
    logic [3:0]  rd_addr = '0;
    logic        tb_we = 1'b0;
    logic [3:0]  tb_waddr = '0;
    logic [35:0] tb_wdata = '0;
    always @(posedge clk) begin
        rd_addr <= mem_addr;
        if (mem_we)     mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end
    assign mem_rdata = mem[rd_addr];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tb_write(input logic [3:0] a, input logic [35:0] d);
        @(negedge clk); tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk); tb_we = 1'b0;
    endtask

    task automatic pulse_new_game();
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
    endtask

    // Latency counts clock edges from the accept edge inclusive.
    task automatic do_shot(input logic [3:0] r, input logic [3:0] c,
                           output logic [1:0] res, output int lat, output int we_cnt,
                           output logic [35:0] wd, output logic [3:0] wa,
                           output logic [3:0] addr_after, output logic tout);
        @(negedge clk);
        sif.shot_row = r; sif.shot_col = c; sif.shot_valid = 1'b1; sif.result_ready = 1'b1;
        @(negedge clk);
        sif.shot_valid = 1'b0;
        sif.shot_row = 4'($urandom); sif.shot_col = 4'($urandom);
        lat = 1; we_cnt = 0; wd = '0; wa = '0; tout = 1'b0;
        while (!sif.result_valid) begin
            if (mem_we) begin we_cnt++; wd = mem_wdata; wa = mem_addr; end
            if (lat > 8) begin tout = 1'b1; break; end
            @(negedge clk); lat++;
        end
        res = sif.result;
        addr_after = mem_addr;
    endtask

    // Reference model: board of 3-bit cells and game counters
    logic [2:0] mb [0:10][0:11];
    int         m_hits;
    bit         m_go;

    function automatic logic [35:0] pack_row(input int r);
        logic [35:0] p;
        p = '0;
        for (int c = 0; c < 12; c++) p[3*c +: 3] = mb[r][c];
        return p;
    endfunction

    task automatic model_shot(input int r, input int c, output logic [1:0] res);
        if (r >= 11 || c >= 12)  res = INVALID;
        else if (mb[r][c][1])    res = REPEAT;
        else begin
            mb[r][c][1] = 1'b1;
            if (mb[r][c][0]) begin
                res = HIT;
                if (m_hits < 17) m_hits++;
                if (m_hits == 17) m_go = 1'b1;
            end else res = MISS;
        end
    endtask

    typedef struct {
        bit          preset;
        logic [35:0] pdata;
        logic [3:0]  row, col;
        logic [1:0]  res;
        int          lat;
        int          we;
        logic [35:0] wdata;
        logic [3:0]  addr;
        logic [5:0]  hits;
    } vec_t;

    vec_t vecs [10];

    logic [1:0]  res, eres;
    int          lat, we_cnt;
    logic [35:0] wd;
    logic [3:0]  wa, aa;
    logic        tout;
    int          ship_r [17];
    int          ship_c [17];

    initial begin
        sif.shot_valid = 1'b0; sif.shot_row = '0; sif.shot_col = '0; sif.result_ready = 1'b1;

        vecs[0] = '{1, 36'h0,         4'd3,  4'd5,  MISS,    3, 1, 36'h000010000, 4'd3,  6'd0};
        vecs[1] = '{1, 36'h1,         4'd2,  4'd0,  HIT,     3, 1, 36'h000000003, 4'd2,  6'd1};
        vecs[2] = '{0, 36'h0,         4'd2,  4'd0,  REPEAT,  3, 0, 36'h0,         4'd2,  6'd1};
        vecs[3] = '{0, 36'h0,         4'd11, 4'd0,  INVALID, 1, 0, 36'h0,         4'd2,  6'd1};
        vecs[4] = '{0, 36'h0,         4'd0,  4'd12, INVALID, 1, 0, 36'h0,         4'd2,  6'd1};
        vecs[5] = '{1, 36'hA00000000, 4'd5,  4'd11, HIT,     3, 1, 36'hE00000000, 4'd5,  6'd2};
        vecs[6] = '{1, 36'hFFFFFFFFD, 4'd10, 4'd0,  HIT,     3, 1, 36'hFFFFFFFFF, 4'd10, 6'd3};
        vecs[7] = '{0, 36'h0,         4'd15, 4'd15, INVALID, 1, 0, 36'h0,         4'd10, 6'd3};
        vecs[8] = '{0, 36'h0,         4'd10, 4'd1,  REPEAT,  3, 0, 36'h0,         4'd10, 6'd3};
        vecs[9] = '{1, 36'h000000020, 4'd4,  4'd1,  MISS,    3, 1, 36'h000000030, 4'd4,  6'd3};

        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_shot_ready", sif.shot_ready, 1);
        chk("rst_result_valid", sif.result_valid, 0);
        chk("rst_result", sif.result, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].preset) tb_write(vecs[i].row, vecs[i].pdata);
            do_shot(vecs[i].row, vecs[i].col, res, lat, we_cnt, wd, wa, aa, tout);
            chk($sformatf("v%0d_timeout", i), tout, 0);
            chk($sformatf("v%0d_result", i), res, vecs[i].res);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_we_pulses", i), we_cnt, vecs[i].we);
            if (vecs[i].we != 0) begin
                chk($sformatf("v%0d_wdata", i), wd, vecs[i].wdata);
                chk($sformatf("v%0d_waddr", i), wa, vecs[i].row);
            end
            chk($sformatf("v%0d_mem_addr", i), aa, vecs[i].addr);
            chk($sformatf("v%0d_hit_count", i), hit_count, vecs[i].hits);
        end

        // Result held while the consumer stalls
        tb_write(4'd1, 36'h40);
        @(negedge clk);
        sif.shot_row = 4'd1; sif.shot_col = 4'd2; sif.shot_valid = 1'b1; sif.result_ready = 1'b0;
        @(negedge clk); sif.shot_valid = 1'b0;
        for (int k = 0; k < 8 && !sif.result_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("hold_result_valid", sif.result_valid, 1);
            chk("hold_result", sif.result, HIT);
            chk("hold_shot_ready", sif.shot_ready, 0);
            @(negedge clk);
        end
        sif.result_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_valid", sif.result_valid, 0);
        chk("hold_release_ready", sif.shot_ready, 1);
        chk("hold_hit_count", hit_count, 4);

        // Asynchronous reset during the write cycle of a HIT
        tb_write(4'd7, 36'h200);
        @(negedge clk);
        sif.shot_row = 4'd7; sif.shot_col = 4'd3; sif.shot_valid = 1'b1;
        @(negedge clk); sif.shot_valid = 1'b0;
        @(negedge clk);
        chk("arst_we_before", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_we", mem_we, 0);
        chk("arst_hit_count", hit_count, 0);
        chk("arst_result", sif.result, 0);
        chk("arst_result_valid", sif.result_valid, 0);
        chk("arst_shot_ready", sif.shot_ready, 1);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_wdata", mem_wdata, 0);
        chk("arst_game_over", game_over, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("arst_row_untouched", mem[7], 36'h200);

        // Random game against the reference model
        pulse_new_game();
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 12; c++) mb[r][c] = {1'($urandom_range(0, 1)), 2'b00};
        for (int s = 0; s < 17; ) begin
            int r, c;
            r = $urandom_range(0, 10); c = $urandom_range(0, 11);
            if (!mb[r][c][0]) begin mb[r][c][0] = 1'b1; ship_r[s] = r; ship_c[s] = c; s++; end
        end
        for (int r = 0; r < 11; r++) tb_write(4'(r), pack_row(r));
        m_hits = 0; m_go = 1'b0;
        for (int n = 0; n < 300 && !m_go; n++) begin
            int r, c, k;
            case ($urandom_range(0, 3))
                0:       begin r = $urandom_range(0, 15); c = $urandom_range(0, 15); end
                1:       begin r = $urandom_range(0, 10); c = $urandom_range(0, 11); end
                default: begin k = $urandom_range(0, 16); r = ship_r[k]; c = ship_c[k]; end
            endcase
            model_shot(r, c, eres);
            do_shot(4'(r), 4'(c), res, lat, we_cnt, wd, wa, aa, tout);
            chk("rnd_timeout", tout, 0);
            chk("rnd_result", res, eres);
            chk("rnd_latency", lat, (eres == INVALID) ? 1 : 3);
            chk("rnd_we_pulses", we_cnt, (eres == HIT || eres == MISS) ? 1 : 0);
            if (eres == HIT || eres == MISS) begin
                chk("rnd_wdata", wd, pack_row(r));
                chk("rnd_waddr", wa, r);
            end
            chk("rnd_hit_count", hit_count, m_hits);
            chk("rnd_game_over", game_over, m_go);
        end
        chk("end_game_over", game_over, 1);
        chk("end_hit_count", hit_count, 17);

        @(negedge clk); sif.shot_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("over_shot_ready", sif.shot_ready, 0);
            chk("over_no_result", sif.result_valid, 0);
            chk("over_no_we", mem_we, 0);
        end
        sif.shot_valid = 1'b0;
        pulse_new_game();
        chk("ng_hit_count", hit_count, 0);
        chk("ng_game_over", game_over, 0);
        chk("ng_shot_ready", sif.shot_ready, 1);
        for (int r = 0; r < 11; r++) chk($sformatf("board_row%0d", r), mem[r], pack_row(r));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
